// File: rtl/ctrl_defs.sv
// rtl/ctrl_defs.sv - shared opcode, state and control-field encodings for the multicycle controller
package ctrl_defs;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // alu_op encodings consumed by alu_control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand mux selects
    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_ONE    = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_BRANCH = 2'b11;

    // PC source mux selects
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Controller states; encodings 14 and 15 are unreachable and treated as ILLEGAL
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_IMM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    // Full datapath control word produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctrl_word_t;

    // Dispatch target out of DECODE for a given opcode
    function automatic state_t decode_dispatch(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE: nxt = S_EXEC_R;
            OP_ADDI:  nxt = S_EXEC_I;
            OP_LW:    nxt = S_MEM_ADDR;
            OP_SW:    nxt = S_MEM_ADDR;
            OP_BEQ:   nxt = S_BRANCH;
            OP_JMP:   nxt = S_JUMP;
            OP_HALT:  nxt = S_HALT;
            default:  nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // Terminal states (including unreachable encodings) stop the controller
    function automatic logic is_terminal(input state_t st);
        return (st == S_HALT) || (st == S_ILLEGAL) || (st > S_ILLEGAL);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// rtl/ctrl_out_decode.sv - combinational state (+mem_ready) to control-word decode
import ctrl_defs::*;

module ctrl_out_decode (
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    // Moore decode; only the FETCH IR/PC loads look at mem_ready
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.iord      = 1'b0;
                cw.alu_src_a = 1'b0;
                cw.alu_src_b = ALU_B_ONE;
                cw.alu_op    = ALU_OP_ADD;
                cw.pc_src    = PC_SRC_ALU;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                cw.alu_src_a = 1'b0;
                cw.alu_src_b = ALU_B_BRANCH;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = ALU_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.reg_dst    = 1'b0;
            end
            S_MEM_WRITE: begin
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_EXEC_R: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = ALU_B_REG;
                cw.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = ALU_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_IMM_WB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b0;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = ALU_B_REG;
                cw.alu_op        = ALU_OP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PC_SRC_JUMP;
            end
            S_HALT: begin
                cw.halted = 1'b1;
            end
            default: begin
                cw.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle main controller; MAIN_CTRL_PERF_CNT_EN adds cycle/instret counters
import ctrl_defs::*;

module main_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal
`ifdef MAIN_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t     state;
    state_t     state_next;
    ctrl_word_t cw;

    // The zero flag qualifies pc_write_cond inside the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    // Next-state logic; unreachable encodings fall into ILLEGAL
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_next = decode_dispatch(opcode);
            S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    state_next = S_ALU_WB;
            S_ALU_WB:    state_next = S_FETCH;
            S_EXEC_I:    state_next = S_IMM_WB;
            S_IMM_WB:    state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            S_ILLEGAL:   state_next = S_ILLEGAL;
            default:     state_next = S_ILLEGAL;
        endcase
    end

    // State register; reset returns the controller to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    ctrl_out_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .cw        (cw)
    );

    // FETCH would otherwise load IR/PC during reset whenever mem_ready is high
    assign pc_write      = cw.pc_write & ~rst;
    assign pc_write_cond = cw.pc_write_cond & ~rst;
    assign ir_write      = cw.ir_write & ~rst;
    assign reg_write     = cw.reg_write & ~rst;
    assign mem_write     = cw.mem_write & ~rst;
    assign pc_src        = cw.pc_src;
    assign iord          = cw.iord;
    assign mem_read      = cw.mem_read;
    assign reg_dst       = cw.reg_dst;
    assign mem_to_reg    = cw.mem_to_reg;
    assign alu_src_a     = cw.alu_src_a;
    assign alu_src_b     = cw.alu_src_b;
    assign alu_op        = cw.alu_op;
    assign halted        = cw.halted;
    assign illegal       = cw.illegal;

`ifdef MAIN_CTRL_PERF_CNT_EN
    // Cycles spent running and instructions retired (each return to FETCH)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (!is_terminal(state)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if ((state_next == S_FETCH) && (state != S_FETCH)) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - directed self-checking bench for main_control_fsm
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
`ifdef MAIN_CTRL_PERF_CNT_EN
    logic [15:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    main_control_fsm #(.CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .halted        (halted),
        .illegal       (illegal)
`ifdef MAIN_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted, illegal}
    logic [17:0] obs;
    assign obs = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted, illegal};

    //                       pcw  pcwc pcs    iord mr   mw   irw  rd   m2r  rw   asa  asb    aop    h    il
    localparam logic [17:0] W_FETCH_WAIT = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_FETCH      = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_DECODE     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_EXEC_R     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0};
    localparam logic [17:0] W_ALU_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_ADDR_IMM   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_IMM_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_MEM_READ   = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_MEM_WB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_MEM_WRITE  = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_BRANCH     = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,1'b0};
    localparam logic [17:0] W_JUMP       = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] W_HALT       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0};
    localparam logic [17:0] W_ILLEGAL    = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1};

    task automatic check_word(input logic [17:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One controller cycle: drive inputs after the falling edge, then sample
    task automatic step(input logic rdy, input logic z, input logic [17:0] expv, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
        check_word(expv, tag);
    endtask

    // Reset pulse across one rising edge, released with mem_ready low so FETCH holds
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_word(W_FETCH_WAIT, tag);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 4'b0000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        do_reset("reset_state");
`ifdef MAIN_CTRL_PERF_CNT_EN
        checks++;
        assert (cycle_cnt === 16'd0 && instret_cnt === 16'd0) else begin
            errors++;
            $error("FAIL cnt_reset observed=%0d/%0d expected=0/0", cycle_cnt, instret_cnt);
        end
`endif

        // R-type, no wait states
        opcode = 4'b0000;
        step(1'b1, 1'b0, W_FETCH,  "r_fetch");
        step(1'b1, 1'b0, W_DECODE, "r_decode");
        step(1'b1, 1'b0, W_EXEC_R, "r_exec");
        step(1'b1, 1'b0, W_ALU_WB, "r_wb");

        // ADDI
        opcode = 4'b0001;
        step(1'b1, 1'b0, W_FETCH,    "addi_fetch");
        step(1'b1, 1'b0, W_DECODE,   "addi_decode");
        step(1'b1, 1'b0, W_ADDR_IMM, "addi_exec");
        step(1'b1, 1'b0, W_IMM_WB,   "addi_wb");

        // LW with two wait cycles in MEM_READ: seven cycles total
        opcode = 4'b0010;
        step(1'b1, 1'b0, W_FETCH,    "lw_fetch");
        step(1'b1, 1'b0, W_DECODE,   "lw_decode");
        step(1'b1, 1'b0, W_ADDR_IMM, "lw_addr");
        step(1'b0, 1'b0, W_MEM_READ, "lw_read_wait1");
        step(1'b0, 1'b0, W_MEM_READ, "lw_read_wait2");
        step(1'b1, 1'b0, W_MEM_READ, "lw_read_done");
        step(1'b1, 1'b0, W_MEM_WB,   "lw_wb");

        // SW with one FETCH wait
        opcode = 4'b0011;
        step(1'b0, 1'b0, W_FETCH_WAIT, "sw_fetch_wait");
        step(1'b1, 1'b0, W_FETCH,      "sw_fetch");
        step(1'b1, 1'b0, W_DECODE,     "sw_decode");
        step(1'b1, 1'b0, W_ADDR_IMM,   "sw_addr");
        step(1'b1, 1'b0, W_MEM_WRITE,  "sw_write");

        // BEQ taken and not taken: identical control sequence
        opcode = 4'b0100;
        step(1'b1, 1'b1, W_FETCH,  "beq1_fetch");
        step(1'b1, 1'b1, W_DECODE, "beq1_decode");
        step(1'b1, 1'b1, W_BRANCH, "beq1_branch");
        step(1'b1, 1'b0, W_FETCH,  "beq2_fetch");
        step(1'b1, 1'b0, W_DECODE, "beq2_decode");
        step(1'b1, 1'b0, W_BRANCH, "beq2_branch");

        // JMP
        opcode = 4'b0101;
        step(1'b1, 1'b0, W_FETCH,  "jmp_fetch");
        step(1'b1, 1'b0, W_DECODE, "jmp_decode");
        step(1'b1, 1'b0, W_JUMP,   "jmp_jump");

        // HALT is sticky for ten further cycles
        opcode = 4'b1111;
        step(1'b1, 1'b0, W_FETCH,  "halt_fetch");
        step(1'b1, 1'b0, W_DECODE, "halt_decode");
        step(1'b1, 1'b0, W_HALT,   "halt_enter");
        for (int i = 0; i < 10; i++) begin
            step(i[0], 1'b0, W_HALT, "halt_hold");
        end
        do_reset("halt_reset");
        step(1'b1, 1'b0, W_FETCH, "after_halt_fetch");

        // Undefined opcode 0111
        opcode = 4'b0111;
        step(1'b1, 1'b0, W_DECODE,  "ill_decode");
        step(1'b1, 1'b0, W_ILLEGAL, "ill_enter");
        step(1'b1, 1'b0, W_ILLEGAL, "ill_hold1");
        step(1'b0, 1'b0, W_ILLEGAL, "ill_hold2");
        do_reset("ill_reset");

        // Reset asserted mid-SW while the write is stalled
        opcode = 4'b0011;
        step(1'b1, 1'b0, W_FETCH,     "swr_fetch");
        step(1'b1, 1'b0, W_DECODE,    "swr_decode");
        step(1'b1, 1'b0, W_ADDR_IMM,  "swr_addr");
        step(1'b0, 1'b0, W_MEM_WRITE, "swr_write_wait");
        rst = 1'b1;
        #1;
        check_word(W_FETCH_WAIT, "swr_async_reset");
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, W_FETCH,  "swr_release_fetch");
        step(1'b1, 1'b0, W_DECODE, "swr_release_decode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
